// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framer: frame limits, parity
// encodings, FSM state codes and the latched per-frame configuration.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_SAMPLE     = 7;
    localparam int MIN_DATA       = 5;
    localparam int MAX_DATA       = 9;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_PARITY    = 3'd3;
    localparam state_t ST_STOP1     = 3'd4;
    localparam state_t ST_STOP2     = 3'd5;
    localparam state_t ST_WAIT_IDLE = 3'd6;

    // Frame format captured at the start bit so mid-frame input changes are ignored.
    typedef struct packed {
        logic       use_parity;
        logic       odd;
        logic       two_stop;
        logic [3:0] len;
    } cfg_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < 4'(MIN_DATA)) return 4'(MIN_DATA);
        if (len > 4'(MAX_DATA)) return 4'(MAX_DATA);
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous serial line; resets to the
// idle (high) level so no false start bit is seen when reset releases.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_16bd,
    input  logic rst,
    input  logic serial,
    output logic synced
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], serial};
        end
    end

    assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_processor.sv
// UART receive framer: 16x oversampled start/data/parity/stop recovery with a
// one-cycle strobe for frames that pass the parity and stop-bit checks.
module uart_processor
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_16bd,
    input  logic                rst,
    input  logic                Rx,
    input  logic                parity,
    input  logic                parity_type,
    input  logic                stop_bits,
    input  logic [3:0]          frame_length,
    output logic [MAX_DATA-1:0] frame,
    output logic                frame_valid
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    logic                rxs;
    state_t              state;
    cfg_t                cfg;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          idx;
    logic [MAX_DATA-1:0] data;
    logic                par_acc;
    logic                perr;
    logic                stop_ok;
    logic                mid;
    logic                frame_end;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_16bd(clk_16bd),
        .rst     (rst),
        .serial  (Rx),
        .synced  (rxs)
    );

    assign mid       = (cnt == CNT_W'(MID_SAMPLE));
    assign frame_end = mid && ((state == ST_STOP2) ||
                               (state == ST_STOP1 && !cfg.two_stop));

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge values, and a later assignment in the same
    // block deliberately overrides an earlier one (used at frame end).
    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state       <= ST_IDLE;
            cfg         <= '{use_parity: 1'b0, odd: PAR_EVEN, two_stop: 1'b0,
                             len: 4'(MIN_DATA)};
            cnt         <= '0;
            idx         <= '0;
            data        <= '0;
            par_acc     <= 1'b0;
            perr        <= 1'b0;
            stop_ok     <= 1'b1;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;

            // Bit-period counter only runs while a frame is in progress.
            if (state == ST_IDLE || state == ST_WAIT_IDLE) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(OVERSAMPLE - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state   <= ST_START;
                        cfg     <= '{use_parity: parity, odd: parity_type,
                                     two_stop: stop_bits,
                                     len: clamp_len(frame_length)};
                        idx     <= '0;
                        data    <= '0;
                        par_acc <= 1'b0;
                        perr    <= 1'b0;
                        stop_ok <= 1'b1;
                    end
                end
                ST_START: begin
                    if (mid) state <= rxs ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (mid) begin
                        data[idx] <= rxs;
                        par_acc   <= par_acc ^ rxs;
                        idx       <= idx + 4'd1;
                        if (idx == cfg.len - 4'd1) begin
                            state <= cfg.use_parity ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (mid) begin
                        perr  <= par_acc ^ rxs ^ (cfg.odd == PAR_ODD);
                        state <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (mid) begin
                        stop_ok <= rxs;
                        if (cfg.two_stop) state <= ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    // Final sample handled by the frame-end logic below.
                end
                ST_WAIT_IDLE: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A low final stop bit is a framing error; hold off until the line idles.
            if (frame_end) begin
                frame       <= data;
                frame_valid <= !perr && stop_ok && rxs;
                state       <= rxs ? ST_IDLE : ST_WAIT_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_processor.sv
// Self-checking bench for uart_processor: directed frames plus randomized
// frames compared against a behavioural frame model.
module tb_uart_processor;

    localparam int OS = 16;

    logic       clk_16bd = 1'b0;
    logic       rst;
    logic       Rx;
    logic       parity;
    logic       parity_type;
    logic       stop_bits;
    logic [3:0] frame_length;
    logic [8:0] frame;
    logic       frame_valid;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         long_pulses = 0;
    logic       fv_q = 1'b0;
    logic [8:0] last_frame = '0;

    always #10 clk_16bd = ~clk_16bd;

    uart_processor dut (
        .clk_16bd    (clk_16bd),
        .rst         (rst),
        .Rx          (Rx),
        .parity      (parity),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .frame_length(frame_length),
        .frame       (frame),
        .frame_valid (frame_valid)
    );

    always @(negedge clk_16bd) begin
        if (frame_valid) begin
            pulses <= pulses + 1;
            if (fv_q) long_pulses <= long_pulses + 1;
        end
        fv_q <= frame_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected frame contents and validity derived from the bits put on the line.
    function automatic void model(input logic [8:0] d, input logic [3:0] fl,
                                  input logic par, input logic ptype, input logic pbit,
                                  input logic s1, input logic s2, input logic two,
                                  output logic [8:0] f, output logic v);
        int len;
        int ones;
        len  = (fl < 4'd5) ? 5 : (fl > 4'd9) ? 9 : int'(fl);
        f    = '0;
        ones = 0;
        for (int i = 0; i < len; i++) begin
            f[i] = d[i];
            ones += int'(d[i]);
        end
        v = s1 && (!two || s2) && (!par || (((ones + int'(pbit)) % 2) == int'(ptype)));
    endfunction

    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (OS) @(negedge clk_16bd);
    endtask

    task automatic send_frame(input string tag, input logic [8:0] d, input logic [3:0] fl,
                              input logic par, input logic ptype, input logic pbit,
                              input logic s1, input logic s2, input logic two,
                              input int gap);
        logic [8:0] exp_f;
        logic       exp_v;
        int         len;
        int         p0;
        parity       = par;
        parity_type  = ptype;
        stop_bits    = two;
        frame_length = fl;
        model(d, fl, par, ptype, pbit, s1, s2, two, exp_f, exp_v);
        len = (fl < 4'd5) ? 5 : (fl > 4'd9) ? 9 : int'(fl);
        p0  = pulses;
        drive_bit(1'b0);
        // The frame format must stay as latched at the start bit.
        parity       = 1'($urandom);
        parity_type  = 1'($urandom);
        stop_bits    = 1'($urandom);
        frame_length = 4'($urandom);
        for (int i = 0; i < len; i++) drive_bit(d[i]);
        if (par) drive_bit(pbit);
        drive_bit(s1);
        if (two) drive_bit(s2);
        Rx = 1'b1;
        repeat (gap) @(negedge clk_16bd);
        check({tag, " frame"}, 32'(frame), 32'(exp_f));
        check({tag, " pulse"}, 32'(pulses - p0), 32'(exp_v));
        last_frame = exp_f;
    endtask

    initial begin
        logic [8:0] d;
        logic [3:0] fl;
        logic       par, ptype, pbit, s1, s2, two;
        int         gap;
        int         p0;

        rst          = 1'b1;
        Rx           = 1'b1;
        parity       = 1'b0;
        parity_type  = 1'b0;
        stop_bits    = 1'b0;
        frame_length = 4'd8;
        repeat (3) @(negedge clk_16bd);
        check("reset frame", 32'(frame), 32'h0);
        check("reset valid", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk_16bd);

        send_frame("t1 even ok",     9'h065, 4'd8, 1, 0, 0, 1, 1, 0, 0);
        send_frame("t2 even bad",    9'h047, 4'd8, 1, 0, 1, 1, 1, 0, 0);
        send_frame("t2 next",        9'h065, 4'd8, 1, 0, 0, 1, 1, 0, 0);
        send_frame("t3 stop low",    9'h065, 4'd8, 1, 0, 0, 0, 1, 0, 8);
        send_frame("t3 next",        9'h047, 4'd8, 1, 0, 0, 1, 1, 0, 0);
        send_frame("t4 no parity",   9'h065, 4'd8, 0, 0, 0, 1, 1, 0, 0);
        send_frame("t4 odd bad",     9'h065, 4'd8, 1, 1, 0, 1, 1, 0, 0);
        send_frame("t4 odd ok",      9'h047, 4'd8, 1, 1, 1, 1, 1, 0, 0);
        send_frame("t5 two stop ok", 9'h065, 4'd8, 1, 0, 0, 1, 1, 1, 0);
        send_frame("t5 stop2 low",   9'h047, 4'd8, 1, 0, 1, 1, 0, 1, 8);
        send_frame("t5 odd stop2 0", 9'h047, 4'd8, 1, 1, 1, 1, 0, 1, 8);
        send_frame("t5 stop1 low",   9'h065, 4'd8, 1, 0, 0, 0, 1, 1, 0);
        send_frame("len 3 clamp",    9'h1ff, 4'd3, 0, 0, 0, 1, 1, 0, 0);
        send_frame("len 12 clamp",   9'h1a5, 4'd12, 1, 0, 1, 1, 1, 0, 0);
        send_frame("len 5",          9'h0f3, 4'd5, 1, 1, 0, 1, 1, 0, 0);
        send_frame("len 9",          9'h155, 4'd9, 1, 1, 0, 1, 1, 1, 0);
        send_frame("pre glitch",     9'h065, 4'd8, 0, 0, 0, 1, 1, 0, 4);

        // Short low pulse while idle must be rejected as a glitch.
        p0 = pulses;
        Rx = 1'b0;
        repeat (4) @(negedge clk_16bd);
        Rx = 1'b1;
        repeat (250) @(negedge clk_16bd);
        check("glitch pulse", 32'(pulses - p0), 32'h0);
        check("glitch frame", 32'(frame), 32'(last_frame));

        // Reset in the middle of the data bits discards the partial frame.
        parity = 1'b0;
        stop_bits = 1'b0;
        frame_length = 4'd8;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (5) @(negedge clk_16bd);
        rst = 1'b1;
        Rx  = 1'b1;
        repeat (2) @(negedge clk_16bd);
        check("rst frame", 32'(frame), 32'h0);
        check("rst valid", 32'(frame_valid), 32'h0);
        rst = 1'b0;
        p0  = pulses;
        repeat (300) @(negedge clk_16bd);
        check("rst no pulse", 32'(pulses - p0), 32'h0);
        check("rst frame hold", 32'(frame), 32'h0);
        send_frame("post rst", 9'h047, 4'd8, 1, 1, 1, 1, 1, 0, 0);

        for (int n = 0; n < 30; n++) begin
            d     = 9'($urandom);
            fl    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(5, 9));
            par   = 1'($urandom);
            ptype = 1'($urandom);
            two   = 1'($urandom);
            begin
                logic [8:0] f_ok;
                logic       v_ok;
                model(d, fl, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, f_ok, v_ok);
                pbit = 1'($countones(f_ok) % 2) ^ ptype;
            end
            if ($urandom_range(0, 5) == 0) pbit = ~pbit;
            s1  = ($urandom_range(0, 7) != 0);
            s2  = ($urandom_range(0, 7) != 0);
            gap = ((two ? s2 : s1) == 1'b0) ? 8 : int'($urandom_range(0, 20));
            send_frame($sformatf("rnd%0d", n), d, fl, par, ptype, pbit, s1, s2, two, gap);
        end

        check("pulse width", 32'(long_pulses), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
